// File: rtl/osd_stm_multi_if.sv
// -----------------------------------------------------------------------------
// osd_stm_multi_if
// Purpose : bundles the register-access bus and the output event stream of
//           osd_stm_multi so that the core and its neighbours connect through
//           one port.
// Signals : reg_request/reg_write/reg_addr/reg_wdata  regaccess -> core
//           reg_ack/reg_err/reg_rdata                  core -> regaccess
//           out_data/out_valid                         core -> packetizer
//           out_ready                                  packetizer -> core
// Modports: slave  = the trace core (answers registers, sources events)
//           master = the surrounding logic (issues registers, sinks events)
// -----------------------------------------------------------------------------
interface osd_stm_multi_if #(
  parameter int EW = 130
);
  logic          reg_request;
  logic          reg_write;
  logic [15:0]   reg_addr;
  logic [15:0]   reg_wdata;
  logic          reg_ack;
  logic          reg_err;
  logic [15:0]   reg_rdata;
  logic [EW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  reg_request, reg_write, reg_addr, reg_wdata, out_ready,
    output reg_ack, reg_err, reg_rdata, out_data, out_valid
  );

  modport master (
    output reg_request, reg_write, reg_addr, reg_wdata, out_ready,
    input  reg_ack, reg_err, reg_rdata, out_data, out_valid
  );
endinterface

// File: rtl/osd_stm_multi.sv
// -----------------------------------------------------------------------------
// osd_stm_multi
// Purpose : multi-channel software trace core. Each of NCH trace ports is
//           timestamped on capture, parked in a one-entry holding register and
//           round-robin arbitrated into a shared DEPTH-entry event FIFO.
//           A runtime channel-enable mask and (optionally) lost-event counters
//           are reachable over the register bus.
// Ports   : i_clk          clock (single domain)
//           i_rst          synchronous active-high reset
//           i_trace_valid  per-channel event strobe [NCH]
//           i_trace_id     per-channel 16-bit id, channel c at [16c+15:16c]
//           i_trace_value  per-channel XLEN value, channel c at [XLEN*c +: XLEN]
//           i_stall        suppresses capture on all channels
//           bus            osd_stm_multi_if.slave (register bus + event stream)
//           out_data layout: {lost[15:0], value, trace_id, channel, timestamp}
// Config  : define OSD_STM_LOSTCNT_EN to build the per-channel lost counters
//           and the total-drop register 0x203. Without it the lost field is 0,
//           dropped events vanish silently and reading 0x203 flags reg_err.
// -----------------------------------------------------------------------------
module osd_stm_multi #(
  parameter  int XLEN  = 64,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 16,
  parameter  int TSW   = 32,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int EW    = 16 + XLEN + 16 + CHW + TSW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NCH-1:0]      i_trace_valid,
  input  logic [NCH*16-1:0]   i_trace_id,
  input  logic [NCH*XLEN-1:0] i_trace_value,
  input  logic                i_stall,
  osd_stm_multi_if.slave      bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [15:0] ADDR_XLEN  = 16'h0200;
  localparam logic [15:0] ADDR_NCH   = 16'h0201;
  localparam logic [15:0] ADDR_EN    = 16'h0202;
  localparam logic [15:0] ADDR_TOTAL = 16'h0203;

  // Registers
  logic [TSW-1:0]  r_ts;
  logic [NCH-1:0]  r_hold_vld;
  logic [XLEN-1:0] r_hold_val [NCH];
  logic [15:0]     r_hold_id  [NCH];
  logic [TSW-1:0]  r_hold_ts  [NCH];
  logic [NCH-1:0]  r_en;
  logic [CHW-1:0]  r_rr;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  // Wires
  logic [NCH-1:0]  w_cap;
  logic [NCH-1:0]  w_load;
  logic [NCH-1:0]  w_drop;
  logic [NCH-1:0]  w_drain;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_can_push;
  logic            w_gnt_vld;
  logic [CHW-1:0]  w_gnt_idx;
  logic            w_push;
  logic [15:0]     w_gnt_lost;
  logic [EW-1:0]   w_entry;
  logic            w_en_wr;
  logic            w_unused;

  // Channel index reached by stepping 'off' places past 'base', modulo NCH.
  function automatic logic [CHW-1:0] rr_slot(input logic [CHW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) begin
      s = s - NCH;
    end else begin
      s = s;
    end
    return CHW'(s);
  endfunction

  // FIFO status: extra pointer MSB distinguishes full from empty.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && bus.out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_can_push = !w_full || w_pop;

  // Round-robin search for the first full holding register at or after r_rr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_gnt_vld && r_hold_vld[rr_slot(r_rr, i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = rr_slot(r_rr, i);
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
  end

  assign w_push = w_gnt_vld && w_can_push;

  // Capture qualification; a holding reg drained this cycle may reload at once.
  always_comb begin
    w_cap   = '0;
    w_load  = '0;
    w_drop  = '0;
    w_drain = '0;
    for (int c = 0; c < NCH; c++) begin
      w_drain[c] = w_push && (w_gnt_idx == CHW'(c));
      w_cap[c]   = i_trace_valid[c] && r_en[c] && !i_stall;
      w_load[c]  = w_cap[c] && (!r_hold_vld[c] || w_drain[c]);
      w_drop[c]  = w_cap[c] && r_hold_vld[c] && !w_drain[c];
    end
  end

  assign w_entry = {w_gnt_lost, r_hold_val[w_gnt_idx], r_hold_id[w_gnt_idx],
                    w_gnt_idx, r_hold_ts[w_gnt_idx]};

  // Free-running timestamp
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TSW'(1);
    end
  end

  // Holding register occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_vld <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_load[c]) begin
          r_hold_vld[c] <= 1'b1;
        end else if (w_drain[c]) begin
          r_hold_vld[c] <= 1'b0;
        end else begin
          r_hold_vld[c] <= r_hold_vld[c];
        end
      end
    end
  end

  // Holding register payload (qualified by r_hold_vld, so no reset needed)
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (w_load[c]) begin
        r_hold_val[c] <= i_trace_value[XLEN*c +: XLEN];
        r_hold_id[c]  <= i_trace_id[16*c +: 16];
        r_hold_ts[c]  <= r_ts;
      end else begin
        r_hold_val[c] <= r_hold_val[c];
        r_hold_id[c]  <= r_hold_id[c];
        r_hold_ts[c]  <= r_hold_ts[c];
      end
    end
  end

  // Round-robin pointer moves past the channel just pushed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= '0;
    end else if (w_push) begin
      r_rr <= (w_gnt_idx == CHW'(NCH - 1)) ? '0 : (w_gnt_idx + CHW'(1));
    end else begin
      r_rr <= r_rr;
    end
  end

  // FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_push ? (r_wr_ptr + (AW+1)'(1)) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? (r_rd_ptr + (AW+1)'(1)) : r_rd_ptr;
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end else begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
    end
  end

  // Output stream; data forced to 0 while empty so stale slots never leak.
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  assign w_en_wr = bus.reg_request && bus.reg_write && (bus.reg_addr == ADDR_EN);

  // Channel enable mask; bits above NCH are not stored
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en <= '1;
    end else if (w_en_wr) begin
      r_en <= bus.reg_wdata[NCH-1:0];
    end else begin
      r_en <= r_en;
    end
  end

`ifdef OSD_STM_LOSTCNT_EN
  logic [15:0] r_lost [NCH];
  logic [15:0] r_total;
  logic [4:0]  w_drop_cnt;
  logic [16:0] w_total_sum;

  assign w_gnt_lost = r_lost[w_gnt_idx];

  // Number of channels dropping an event this cycle
  always_comb begin
    w_drop_cnt = 5'd0;
    for (int c = 0; c < NCH; c++) begin
      w_drop_cnt = w_drop_cnt + 5'(w_drop[c]);
    end
  end

  assign w_total_sum = {1'b0, r_total} + 17'(w_drop_cnt);

  // Per-channel lost counters: handed over with the pushed event, then restart
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_lost[c] <= 16'd0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_drain[c]) begin
          r_lost[c] <= w_drop[c] ? 16'd1 : 16'd0;
        end else if (w_drop[c] && (r_lost[c] != 16'hFFFF)) begin
          r_lost[c] <= r_lost[c] + 16'd1;
        end else begin
          r_lost[c] <= r_lost[c];
        end
      end
    end
  end

  // Saturating total of all drops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total <= 16'd0;
    end else if (w_total_sum[16]) begin
      r_total <= 16'hFFFF;
    end else begin
      r_total <= w_total_sum[15:0];
    end
  end
`else
  assign w_gnt_lost = 16'd0;
`endif

  // Register read data and error decode (answered in the request cycle)
  always_comb begin
    bus.reg_rdata = 16'd0;
    bus.reg_err   = 1'b0;
    if (i_rst || !bus.reg_request) begin
      bus.reg_err = 1'b0;
    end else begin
      case (bus.reg_addr)
        ADDR_XLEN: begin
          bus.reg_rdata = 16'(XLEN);
          bus.reg_err   = bus.reg_write;
        end
        ADDR_NCH: begin
          bus.reg_rdata = 16'(NCH);
          bus.reg_err   = bus.reg_write;
        end
        ADDR_EN: begin
          bus.reg_rdata = 16'(r_en);
          bus.reg_err   = 1'b0;
        end
        ADDR_TOTAL: begin
`ifdef OSD_STM_LOSTCNT_EN
          bus.reg_rdata = r_total;
          bus.reg_err   = bus.reg_write;
`else
          bus.reg_rdata = 16'd0;
          bus.reg_err   = 1'b1;
`endif
        end
        default: begin
          bus.reg_rdata = 16'd0;
          bus.reg_err   = bus.reg_write;
        end
      endcase
    end
  end

  assign bus.reg_ack = 1'b1;

  // Upper write-data bits and (without counters) the drop vector have no sink.
  assign w_unused = &{1'b0, bus.reg_wdata, w_drop};

endmodule
